// File: rtl/dtc_pkg.sv
// Shared types and constants for the decision-tree classifier pipeline.
// Imported by the thermometer decoder and the window accumulator.
package dtc_pkg;

  localparam int FEAT_W    = 9;
  localparam int THERM_W   = 9;
  localparam int LEVEL_W   = 4;
  localparam int LEVEL_MAX = 9;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } dtc_state_e;

endpackage

// File: rtl/dtc_therm_decode.sv
// Thermometer code to level decoder with legality check.
// Pure combinational; level is the popcount of the code.
module dtc_therm_decode
  import dtc_pkg::*;
(
  input  logic [THERM_W-1:0] therm,
  output logic [LEVEL_W-1:0] level,
  output logic               legal
);

  logic [THERM_W-1:0] mask;

  always_comb begin
    level = '0;
    for (int i = 0; i < THERM_W; i++) begin
      level = level + LEVEL_W'(therm[i]);
    end
  end

  // Level 9 shifts the one out, so 0 - 1 wraps to all ones.
  assign mask  = (THERM_W'(1) << level) - THERM_W'(1);
  assign legal = (therm == mask);

endmodule

// File: rtl/dtc_therm_accum.sv
// Per-window accumulator of thermometer levels: sum, min, max, error count.
// Emits one result record per window over a valid/ready handshake.
module dtc_therm_accum
  import dtc_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int SUM_W  = $clog2(9*WINDOW+1),
  parameter int CNT_W  = $clog2(WINDOW+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [THERM_W-1:0] s_therm,
  input  logic               flush,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [SUM_W-1:0]   m_sum,
  output logic [LEVEL_W-1:0] m_min,
  output logic [LEVEL_W-1:0] m_max,
  output logic [CNT_W-1:0]   m_count,
  output logic [CNT_W-1:0]   m_err
);

  localparam logic [LEVEL_W-1:0] LMAX = LEVEL_W'(LEVEL_MAX);
  localparam logic [CNT_W-1:0]   WEND = CNT_W'(WINDOW);

  dtc_state_e state_q, state_d;

  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [LEVEL_W-1:0] min_q, min_d;
  logic [LEVEL_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [SUM_W-1:0]   m_sum_q, m_sum_d;
  logic [LEVEL_W-1:0] m_min_q, m_min_d;
  logic [LEVEL_W-1:0] m_max_q, m_max_d;
  logic [CNT_W-1:0]   m_cnt_q, m_cnt_d;
  logic [CNT_W-1:0]   m_err_q, m_err_d;

  logic [LEVEL_W-1:0] lvl;
  logic               legal;
  logic               accept;
  logic               close;
  logic [SUM_W-1:0]   sum_n;
  logic [LEVEL_W-1:0] min_n;
  logic [LEVEL_W-1:0] max_n;
  logic [CNT_W-1:0]   cnt_n;
  logic [CNT_W-1:0]   err_n;

  dtc_therm_decode u_dec (
    .therm (s_therm),
    .level (lvl),
    .legal (legal)
  );

  assign accept = s_valid & s_ready_q;

  // Running values including the sample accepted this cycle.
  always_comb begin
    sum_n = sum_q;
    min_n = min_q;
    max_n = max_q;
    cnt_n = cnt_q;
    err_n = err_q;
    if (accept) begin
      cnt_n = cnt_q + CNT_W'(1);
      if (legal) begin
        sum_n = sum_q + SUM_W'(lvl);
        min_n = (lvl < min_q) ? lvl : min_q;
        max_n = (lvl > max_q) ? lvl : max_q;
      end else begin
        err_n = err_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    m_sum_d = m_sum_q;
    m_min_d = m_min_q;
    m_max_d = m_max_q;
    m_cnt_d = m_cnt_q;
    m_err_d = m_err_q;
    close   = 1'b0;
    unique case (state_q)
      ACCUM: begin
        close = (accept && cnt_n == WEND) ||
                (flush && cnt_n != '0);
        if (close) begin
          m_sum_d = sum_n;
          m_min_d = min_n;
          m_max_d = max_n;
          m_cnt_d = cnt_n;
          m_err_d = err_n;
          sum_d   = '0;
          min_d   = LMAX;
          max_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          state_d = HOLD;
        end else begin
          sum_d = sum_n;
          min_d = min_n;
          max_d = max_n;
          cnt_d = cnt_n;
          err_d = err_n;
        end
      end
      HOLD: begin
        if (m_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
    s_ready_d = (state_d == ACCUM);
    m_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      sum_q     <= '0;
      min_q     <= LMAX;
      max_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      m_sum_q   <= '0;
      m_min_q   <= LMAX;
      m_max_q   <= '0;
      m_cnt_q   <= '0;
      m_err_q   <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      sum_q     <= sum_d;
      min_q     <= min_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      m_sum_q   <= m_sum_d;
      m_min_q   <= m_min_d;
      m_max_q   <= m_max_d;
      m_cnt_q   <= m_cnt_d;
      m_err_q   <= m_err_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_sum   = m_sum_q;
  assign m_min   = m_min_q;
  assign m_max   = m_max_q;
  assign m_count = m_cnt_q;
  assign m_err   = m_err_q;

endmodule

// File: tb/tb_dtc_therm_accum.sv
// Scoreboard bench for dtc_therm_accum with WINDOW=4.
// Expected window records are queued at drive time, popped on m handshake.
module tb_dtc_therm_accum;

  localparam int WIN = 4;
  localparam int SW  = $clog2(9*WIN+1);
  localparam int CW  = $clog2(WIN+1);

  typedef struct {
    int sum;
    int mn;
    int mx;
    int cnt;
    int err;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [8:0]    s_therm = '0;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [SW-1:0] m_sum;
  logic [3:0]    m_min;
  logic [3:0]    m_max;
  logic [CW-1:0] m_count;
  logic [CW-1:0] m_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_push = 0;
  int n_res = 0;
  rec_t q[$];
  int r_sum = 0, r_mn = 9, r_mx = 0, r_cnt = 0, r_err = 0;

  dtc_therm_accum #(.WINDOW(WIN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_therm (s_therm),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sum   (m_sum),
    .m_min   (m_min),
    .m_max   (m_max),
    .m_count (m_count),
    .m_err   (m_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic void clr_model();
    r_sum = 0; r_mn = 9; r_mx = 0; r_cnt = 0; r_err = 0;
  endfunction

  function automatic void close_model();
    rec_t r;
    r.sum = r_sum; r.mn = r_mn; r.mx = r_mx;
    r.cnt = r_cnt; r.err = r_err;
    q.push_back(r);
    n_push++;
    clr_model();
  endfunction

  function automatic void take(input logic [8:0] c, input bit fl);
    int v, lv;
    v  = int'(c);
    lv = $countones(c);
    r_cnt++;
    if ((v & (v + 1)) == 0) begin
      r_sum += lv;
      if (lv < r_mn) r_mn = lv;
      if (lv > r_mx) r_mx = lv;
    end else begin
      r_err++;
    end
    if (r_cnt == WIN || fl) close_model();
  endfunction

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rdy_timeout", 0, 1);
  endtask

  task automatic send(input logic [8:0] c, input bit fl);
    bit ok;
    wait_rdy(ok);
    if (ok) begin
      s_valid = 1'b1; s_therm = c; flush = fl;
      @(posedge clk);
      #1;
      s_valid = 1'b0; flush = 1'b0;
      take(c, fl);
    end
  endtask

  task automatic flush_only();
    bit ok;
    wait_rdy(ok);
    if (ok) begin
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      if (r_cnt > 0) close_model();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      n_res++;
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        rec_t e;
        e = q.pop_front();
        chk("m_sum", int'(m_sum), e.sum);
        chk("m_min", int'(m_min), e.mn);
        chk("m_max", int'(m_max), e.mx);
        chk("m_count", int'(m_count), e.cnt);
        chk("m_err", int'(m_err), e.err);
      end
    end
  end

  initial begin
    int low;
    int res0;
    logic [8:0] t1 [4];
    logic [8:0] t2 [4];
    t1 = '{9'h00F, 9'h07F, 9'h001, 9'h1FF};
    t2 = '{9'h00F, 9'h005, 9'h0FF, 9'h100};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_sum", int'(m_sum), 0);
    chk("rst_m_min", int'(m_min), 9);
    chk("rst_m_max", int'(m_max), 0);
    chk("rst_m_count", int'(m_count), 0);
    chk("rst_m_err", int'(m_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_s_ready", int'(s_ready), 1);

    m_ready = 1'b1;
    foreach (t1[i]) send(t1[i], 1'b0);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_ready) break;
      low++;
    end
    chk("bubble_cycles", low, 1);
    foreach (t2[i]) send(t2[i], 1'b0);
    drain();

    send(9'h003, 1'b0);
    send(9'h003, 1'b0);
    flush_only();
    drain();
    res0 = n_res;
    flush_only();
    repeat (4) @(posedge clk);
    #1;
    chk("empty_flush_nores", n_res, res0);
    chk("empty_flush_mvalid", int'(m_valid), 0);
    send(9'h007, 1'b1);
    drain();

    @(posedge clk);
    #1;
    m_ready = 1'b0;
    send(9'h001, 1'b0);
    send(9'h003, 1'b0);
    send(9'h007, 1'b0);
    send(9'h00F, 1'b0);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_therm = 9'h1FF;
      @(negedge clk);
      chk("hold_m_valid", int'(m_valid), 1);
      chk("hold_s_ready", int'(s_ready), 0);
      if (q.size() > 0) begin
        chk("hold_m_sum", int'(m_sum), q[0].sum);
        chk("hold_m_count", int'(m_count), q[0].cnt);
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    foreach (t1[i]) send(9'h1FF, 1'b0);
    drain();

    res0 = n_res;
    send(9'h0FF, 1'b0);
    send(9'h0FF, 1'b0);
    send(9'h0FF, 1'b0);
    rst_n = 1'b0;
    clr_model();
    #1;
    chk("midrst_s_ready", int'(s_ready), 0);
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_m_sum", int'(m_sum), 0);
    chk("midrst_m_min", int'(m_min), 9);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready_rel", int'(s_ready), 1);
    chk("midrst_nores", n_res, res0);
    send(9'h001, 1'b0);
    send(9'h001, 1'b0);
    send(9'h003, 1'b0);
    send(9'h003, 1'b0);
    drain();

    foreach (t1[i]) send(9'h002, 1'b0);
    drain();

    chk("result_total", n_res, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end

endmodule
